// File: rtl/nines_eeprom_reader_if.sv
// Request, EEPROM bus and byte-stream signals of the nines-complement EEPROM reader.
// The master modport is the reader itself. The slave modport is its environment: requester, EEPROM and consumer.
interface nines_eeprom_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs_n;
  logic              rom_oe_n;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base_addr, len, rom_data, out_ready,
    output busy, done, rom_addr, rom_cs_n, rom_oe_n, out_data, out_valid
  );

  modport slave (
    output start, base_addr, len, rom_data, out_ready,
    input  busy, done, rom_addr, rom_cs_n, rom_oe_n, out_data, out_valid
  );
endinterface

// File: rtl/nines_eeprom_reader.sv
// Reads a run of consecutive bytes from the nines-complement lookup EEPROM.
// Each byte is handed downstream over a valid/ready stream and held until the consumer accepts it.
module nines_eeprom_reader #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nines_eeprom_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [3:0]        r_wait;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_cs_n;
  logic              r_rom_oe_n;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  logic              w_len_zero;
  logic              w_last_byte;
  logic              w_accept;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_len_zero  = (bus.len == '0);
  assign w_last_byte = (r_remaining == ADDR_W'(1));
  assign w_accept    = r_out_valid && bus.out_ready;
  assign w_next_addr = r_addr + ADDR_W'(1);

  // The address wraps naturally at 2^ADDR_W. The strobes are registered, so reset forces them high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_wait      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rom_addr  <= '0;
      r_rom_cs_n  <= 1'b1;
      r_rom_oe_n  <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_addr      <= bus.base_addr;
            r_remaining <= bus.len;
            if (w_len_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_SETUP;
              r_busy     <= 1'b1;
              r_rom_addr <= bus.base_addr;
              r_rom_cs_n <= 1'b0;
              r_rom_oe_n <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          r_state    <= S_ACCESS;
          r_rom_oe_n <= 1'b0;
          r_wait     <= WAIT_LOAD;
        end

        S_ACCESS: begin
          if (r_wait == '0) begin
            r_state     <= S_HOLD;
            r_out_data  <= bus.rom_data;
            r_out_valid <= 1'b1;
            r_rom_cs_n  <= 1'b1;
            r_rom_oe_n  <= 1'b1;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end

        S_HOLD: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_remaining <= r_remaining - ADDR_W'(1);
            if (w_last_byte) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_SETUP;
              r_addr     <= w_next_addr;
              r_rom_addr <= w_next_addr;
              r_rom_cs_n <= 1'b0;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_rom_cs_n  <= 1'b1;
          r_rom_oe_n  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_cs_n  = r_rom_cs_n;
  assign bus.rom_oe_n  = r_rom_oe_n;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

endmodule

// File: doc/nines_eeprom_reader.md
Name: nines_eeprom_reader

Overview:
- Read-side controller for the nines-complement lookup EEPROM in base_conversion.
- On a start pulse, it reads a run of LEN consecutive bytes beginning at BASE_ADDR, using the EEPROM's active-low chip-select and output-enable.
- Each byte is delivered downstream over a valid/ready stream, and every byte is stalled until the consumer accepts it.
- It sits between the conversion datapath, which requests table rows, and the EEPROM model or device.

Parameters:
- ADDR_W, 16, EEPROM address width.
- DATA_W, 8, EEPROM data width.
- WAIT_CYCLES, 2, number of cycles oe_n is held low before data is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request; honoured only in IDLE.
- base_addr  input  ADDR_W  first address; captured on accepted start.
- len  input  ADDR_W  byte count; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until DONE completes.
- done  output  1  1-cycle pulse when the run completes.
- rom_addr  output  ADDR_W  EEPROM address.
- rom_cs_n  output  1  EEPROM chip select, active low.
- rom_oe_n  output  1  EEPROM output enable, active low.
- rom_data  input  DATA_W  EEPROM data bus.
- out_data  output  DATA_W  captured byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - busy=0, done=0, out_valid=0, out_data=0, rom_addr=0, rom_cs_n=1, rom_oe_n=1.
  - Internal address, remaining count and wait counter are all 0.
- Reset mid-run aborts immediately with no partial output. Bus strobes return high asynchronously.
- States: IDLE, SETUP, ACCESS, HOLD, DONE. All outputs are registered.
- IDLE:
  - start=1 captures base_addr and len.
  - If len=0: go to DONE with no bus cycle.
  - Otherwise: go to SETUP.
- SETUP (1 cycle): rom_addr=current address, rom_cs_n=0, rom_oe_n=1. Go to ACCESS and load the wait counter.
- ACCESS (WAIT_CYCLES cycles): rom_cs_n=0, rom_oe_n=0, rom_addr stable.
  - rom_data is sampled into out_data at the clock edge that ends the last ACCESS cycle.
  - Go to HOLD.
- HOLD: rom_cs_n=1, rom_oe_n=1, out_valid=1, out_data stable.
  - If out_valid && out_ready: the transfer completes, remaining is decremented, and out_valid drops the next cycle.
  - If remaining becomes 0: go to DONE.
  - Otherwise: increment the address and go to SETUP.
  - Without out_ready, HOLD persists indefinitely and out_data does not change.
- DONE (1 cycle): done=1, busy=0 in this cycle. Return to IDLE.
- busy=1 in SETUP, ACCESS and HOLD.
- Cycle timing for WAIT_CYCLES=2 with out_ready=1: start accepted at cycle T, SETUP at T+1, ACCESS at T+2..T+3, out_valid at T+4. Each further byte takes 4 cycles.
- The address wraps from 2^ADDR_W-1 to 0. The wrap is not an error.
- start while busy or in DONE is ignored; base_addr and len are not re-captured.
- Back-to-back: a start asserted in the cycle after DONE (IDLE) is accepted normally.
- rom_data is don't-care outside the ACCESS sample edge. High-Z on it is never sampled.
- Invariant: rom_oe_n=0 implies rom_cs_n=0.

Test Plan:
- Table program (addr0=0x01, 1=0x02, 2=0x04, 3=0x0B, 4=0x12), base_addr=0, len=5, out_ready=1 → out_data 01,02,04,0B,12 in order. First out_valid at start+4, then every 4 cycles. One done pulse at start+21.
- Same run with out_ready low for 6 cycles on byte 2 → out_valid holds with out_data=0x04 stable. No new strobes during the stall. Sequence unchanged, done delayed by 6.
- base_addr=0xFFFE, len=3 → rom_addr 0xFFFE, 0xFFFF, 0x0000. Three bytes delivered, done once.
- len=0 → done pulses at start+1. rom_cs_n and rom_oe_n stay 1. No out_valid.
- start pulsed mid-run with different base_addr → ignored. Original run completes unchanged.
- rst_n asserted during ACCESS → rom_cs_n, rom_oe_n, busy, out_valid all go to their reset values immediately. After release, a new start with base_addr=5, len=1 returns 0x28.
